alu_rs: RTL and testbench

ALU_RS -- requirements
Module: alu_rs

---
 rtl/alu_rs_if.sv | 52 +++++
 rtl/alu_rs.sv | 198 +++++++++++++++++++
 tb/tb_alu_rs.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_if.sv
// Bus bundle for the ALU reservation station: dispatch, CDB and issue.
// master: dispatch stage / CDB source / ALU side.  slave: the station.
interface alu_rs_if #(
    parameter int TAG_W = 5,
    parameter int OP_W  = 4,
    parameter int PC_W  = 32
);
    // dispatch
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [PC_W-1:0]  in_pc;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_rob_id;
    logic             in_rdy1;
    logic [TAG_W-1:0] in_tag1;
    logic [31:0]      in_val1;
    logic             in_rdy2;
    logic [TAG_W-1:0] in_tag2;
    logic [31:0]      in_val2;

    // common data bus
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;

    // issue towards the ALU
    logic             issue_valid;
    logic             issue_ready;
    logic [OP_W-1:0]  issue_op;
    logic [PC_W-1:0]  issue_pc;
    logic [31:0]      issue_instr;
    logic [31:0]      issue_reg1;
    logic [31:0]      issue_reg2;
    logic [TAG_W-1:0] issue_rob_id;

    modport master (
        output in_valid, in_op, in_pc, in_instr, in_rob_id,
               in_rdy1, in_tag1, in_val1, in_rdy2, in_tag2, in_val2,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  in_ready, issue_valid, issue_op, issue_pc, issue_instr,
               issue_reg1, issue_reg2, issue_rob_id
    );

    modport slave (
        input  in_valid, in_op, in_pc, in_instr, in_rob_id,
               in_rdy1, in_tag1, in_val1, in_rdy2, in_tag2, in_val2,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        output in_ready, issue_valid, issue_op, issue_pc, issue_instr,
               issue_reg1, issue_reg2, issue_rob_id
    );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are
// available (directly or via CDB snoop) and issues the oldest ready op.
// Optional feature: define ALU_RS_CDB_ISSUE_EN to let a stored entry issue
// in the same cycle its last operand appears on the CDB.
module alu_rs #(
    parameter int  DEPTH = 4,
    parameter int  TAG_W = 5,
    parameter int  OP_W  = 4,
    parameter int  PC_W  = 32,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    alu_rs_if.slave          bus,
    output logic [CNT_W-1:0] count
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // entry storage
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_rdy1;
    logic [DEPTH-1:0] r_rdy2;
    logic [OP_W-1:0]  r_op    [DEPTH];
    logic [PC_W-1:0]  r_pc    [DEPTH];
    logic [31:0]      r_instr [DEPTH];
    logic [TAG_W-1:0] r_rob   [DEPTH];
    logic [TAG_W-1:0] r_tag1  [DEPTH];
    logic [TAG_W-1:0] r_tag2  [DEPTH];
    logic [31:0]      r_val1  [DEPTH];
    logic [31:0]      r_val2  [DEPTH];

    // r_older[a][b] set means entry a was enqueued before entry b
    logic [DEPTH-1:0] r_older [DEPTH];
    logic [CNT_W-1:0] r_count;

    logic             w_enq;
    logic             w_iss;
    logic             w_issue_valid;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_in_hit1;
    logic             w_in_hit2;
    logic             w_in_rdy1;
    logic             w_in_rdy2;
    logic [31:0]      w_in_val1;
    logic [31:0]      w_in_val2;
    logic [DEPTH-1:0] w_rdy1_eff;
    logic [DEPTH-1:0] w_rdy2_eff;
    logic [DEPTH-1:0] w_issuable;
    logic [DEPTH-1:0] w_sel;
    logic [31:0]      w_opnd1 [DEPTH];
    logic [31:0]      w_opnd2 [DEPTH];

    // A slot freed by this cycle's issue is not counted as free until the next cycle
    assign bus.in_ready = (r_count < CNT_W'(DEPTH)) && !flush;
    assign w_enq        = bus.in_valid && bus.in_ready;
    assign w_iss        = w_issue_valid && bus.issue_ready;
    assign count        = r_count;

    // Operands arriving on the CDB in the dispatch cycle are captured as ready
    assign w_in_hit1 = !bus.in_rdy1 && bus.cdb_valid && (bus.cdb_tag == bus.in_tag1);
    assign w_in_hit2 = !bus.in_rdy2 && bus.cdb_valid && (bus.cdb_tag == bus.in_tag2);
    assign w_in_rdy1 = bus.in_rdy1 || w_in_hit1;
    assign w_in_rdy2 = bus.in_rdy2 || w_in_hit2;
    assign w_in_val1 = w_in_hit1 ? bus.cdb_data : bus.in_val1;
    assign w_in_val2 = w_in_hit2 ? bus.cdb_data : bus.in_val2;

    // Lowest-index free slot; only used when in_ready guarantees one exists
    always_comb begin
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    // Effective operand readiness and values seen by the issue selector
    always_comb begin
        w_rdy1_eff = '0;
        w_rdy2_eff = '0;
        w_issuable = '0;
        w_opnd1    = '{default: '0};
        w_opnd2    = '{default: '0};
        for (int i = 0; i < DEPTH; i++) begin
`ifdef ALU_RS_CDB_ISSUE_EN
            w_rdy1_eff[i] = r_rdy1[i] || (bus.cdb_valid && (bus.cdb_tag == r_tag1[i]));
            w_rdy2_eff[i] = r_rdy2[i] || (bus.cdb_valid && (bus.cdb_tag == r_tag2[i]));
            w_opnd1[i]    = r_rdy1[i] ? r_val1[i] : bus.cdb_data;
            w_opnd2[i]    = r_rdy2[i] ? r_val2[i] : bus.cdb_data;
`else
            w_rdy1_eff[i] = r_rdy1[i];
            w_rdy2_eff[i] = r_rdy2[i];
            w_opnd1[i]    = r_val1[i];
            w_opnd2[i]    = r_val2[i];
`endif
            w_issuable[i] = r_valid[i] && w_rdy1_eff[i] && w_rdy2_eff[i];
        end
    end

    // Oldest issuable entry wins: one with no older issuable entry
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_sel[i] = w_issuable[i];
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && w_issuable[j] && r_older[j][i]) begin
                    w_sel[i] = 1'b0;
                end
            end
        end
    end

    assign w_issue_valid   = (|w_issuable) && !flush;
    assign bus.issue_valid = w_issue_valid;

    // Issue payload mux; all zero when nothing issues
    always_comb begin
        bus.issue_op     = '0;
        bus.issue_pc     = '0;
        bus.issue_instr  = '0;
        bus.issue_reg1   = '0;
        bus.issue_reg2   = '0;
        bus.issue_rob_id = '0;
        if (w_issue_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_sel[i]) begin
                    bus.issue_op     = r_op[i];
                    bus.issue_pc     = r_pc[i];
                    bus.issue_instr  = r_instr[i];
                    bus.issue_reg1   = w_opnd1[i];
                    bus.issue_reg2   = w_opnd2[i];
                    bus.issue_rob_id = r_rob[i];
                end
            end
        end
    end

    // Occupancy, age order and occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_older[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_iss && w_sel[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (w_enq) begin
                r_valid[w_free_idx] <= 1'b1;
                // new entry is younger than every other slot
                for (int j = 0; j < DEPTH; j++) begin
                    if (IDX_W'(j) != w_free_idx) begin
                        r_older[w_free_idx][j] <= 1'b0;
                        r_older[j][w_free_idx] <= 1'b1;
                    end
                end
            end
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_iss);
        end
    end

    // Payload load on enqueue and CDB wakeup of stored operands
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!flush) begin
                if (w_enq && (w_free_idx == IDX_W'(i))) begin
                    r_op[i]    <= bus.in_op;
                    r_pc[i]    <= bus.in_pc;
                    r_instr[i] <= bus.in_instr;
                    r_rob[i]   <= bus.in_rob_id;
                    r_rdy1[i]  <= w_in_rdy1;
                    r_tag1[i]  <= bus.in_tag1;
                    r_val1[i]  <= w_in_val1;
                    r_rdy2[i]  <= w_in_rdy2;
                    r_tag2[i]  <= bus.in_tag2;
                    r_val2[i]  <= w_in_val2;
                end else if (r_valid[i] && bus.cdb_valid) begin
                    if (!r_rdy1[i] && (bus.cdb_tag == r_tag1[i])) begin
                        r_rdy1[i] <= 1'b1;
                        r_val1[i] <= bus.cdb_data;
                    end
                    if (!r_rdy2[i] && (bus.cdb_tag == r_tag2[i])) begin
                        r_rdy2[i] <= 1'b1;
                        r_val2[i] <= bus.cdb_data;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// Testbench for alu_rs: directed scenarios plus randomized traffic checked
// against an in-order queue model of the reservation station.
module tb_alu_rs;
    localparam int DEPTH = 4;
    localparam logic [3:0] OP_ADD = 4'd0;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [2:0] count;

    alu_rs_if #(.TAG_W(5), .OP_W(4), .PC_W(32)) bus ();

    alu_rs #(.DEPTH(DEPTH), .TAG_W(5), .OP_W(4), .PC_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rob;
        logic        rdy1;
        logic [4:0]  tag1;
        logic [31:0] val1;
        logic        rdy2;
        logic [4:0]  tag2;
        logic [31:0] val2;
    } ent_t;

    ent_t mq[$];   // model contents, oldest first
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Oldest entry with both operands available wins
    task automatic model_pick(output logic ev, output int sel, output logic [31:0] v1, output logic [31:0] v2);
        logic a;
        logic b;
        ev  = 1'b0;
        sel = 0;
        v1  = '0;
        v2  = '0;
        if (!flush) begin
            for (int k = 0; k < mq.size(); k++) begin
                a  = mq[k].rdy1;
                b  = mq[k].rdy2;
                v1 = mq[k].val1;
                v2 = mq[k].val2;
`ifdef ALU_RS_CDB_ISSUE_EN
                if (!a && bus.cdb_valid && bus.cdb_tag == mq[k].tag1) begin a = 1'b1; v1 = bus.cdb_data; end
                if (!b && bus.cdb_valid && bus.cdb_tag == mq[k].tag2) begin b = 1'b1; v2 = bus.cdb_data; end
`endif
                if (a && b) begin
                    ev  = 1'b1;
                    sel = k;
                    break;
                end
            end
        end
        if (!ev) begin
            v1 = '0;
            v2 = '0;
        end
    endtask

    // Compare DUT against model for the current inputs, then advance model one edge
    task automatic do_cycle();
        logic        ev;
        logic        enq;
        int          sel;
        logic [31:0] v1;
        logic [31:0] v2;
        ent_t        e;
        #1;
        model_pick(ev, sel, v1, v2);
        check_eq("in_ready", 32'(bus.in_ready), 32'((mq.size() < DEPTH) && !flush));
        check_eq("count", 32'(count), 32'(mq.size()));
        check_eq("issue_valid", 32'(bus.issue_valid), 32'(ev));
        check_eq("issue_op", 32'(bus.issue_op), ev ? 32'(mq[sel].op) : 32'd0);
        check_eq("issue_pc", bus.issue_pc, ev ? mq[sel].pc : 32'd0);
        check_eq("issue_instr", bus.issue_instr, ev ? mq[sel].instr : 32'd0);
        check_eq("issue_rob_id", 32'(bus.issue_rob_id), ev ? 32'(mq[sel].rob) : 32'd0);
        check_eq("issue_reg1", bus.issue_reg1, v1);
        check_eq("issue_reg2", bus.issue_reg2, v2);
        if (flush) begin
            mq.delete();
        end else begin
            enq = bus.in_valid && (mq.size() < DEPTH);
            if (ev && bus.issue_ready) mq.delete(sel);
            if (bus.cdb_valid) begin
                for (int k = 0; k < mq.size(); k++) begin
                    if (!mq[k].rdy1 && mq[k].tag1 == bus.cdb_tag) begin mq[k].rdy1 = 1'b1; mq[k].val1 = bus.cdb_data; end
                    if (!mq[k].rdy2 && mq[k].tag2 == bus.cdb_tag) begin mq[k].rdy2 = 1'b1; mq[k].val2 = bus.cdb_data; end
                end
            end
            if (enq) begin
                e.op = bus.in_op; e.pc = bus.in_pc; e.instr = bus.in_instr; e.rob = bus.in_rob_id;
                e.rdy1 = bus.in_rdy1; e.tag1 = bus.in_tag1; e.val1 = bus.in_val1;
                e.rdy2 = bus.in_rdy2; e.tag2 = bus.in_tag2; e.val2 = bus.in_val2;
                if (!e.rdy1 && bus.cdb_valid && bus.cdb_tag == e.tag1) begin e.rdy1 = 1'b1; e.val1 = bus.cdb_data; end
                if (!e.rdy2 && bus.cdb_valid && bus.cdb_tag == e.tag2) begin e.rdy2 = 1'b1; e.val2 = bus.cdb_data; end
                mq.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_pc = '0; bus.in_instr = '0; bus.in_rob_id = '0;
        bus.in_rdy1 = 1'b0; bus.in_tag1 = '0; bus.in_val1 = '0;
        bus.in_rdy2 = 1'b0; bus.in_tag2 = '0; bus.in_val2 = '0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
        bus.issue_ready = 1'b0;
        flush = 1'b0;
    endtask

    task automatic set_enq(input logic [4:0] rob, input logic r1, input logic [4:0] t1, input logic [31:0] v1,
                           input logic r2, input logic [4:0] t2, input logic [31:0] v2);
        bus.in_valid = 1'b1; bus.in_op = OP_ADD; bus.in_rob_id = rob;
        bus.in_pc = 32'h1000 + 32'(rob); bus.in_instr = 32'h0000_0033 | (32'(rob) << 7);
        bus.in_rdy1 = r1; bus.in_tag1 = t1; bus.in_val1 = v1;
        bus.in_rdy2 = r2; bus.in_tag2 = t2; bus.in_val2 = v2;
    endtask

    task automatic set_cdb(input logic [4:0] tag, input logic [31:0] data);
        bus.cdb_valid = 1'b1; bus.cdb_tag = tag; bus.cdb_data = data;
    endtask

    // Assert reset across one rising edge (called at a falling edge)
    task automatic do_reset();
        flush = 1'b0;
        rst   = 1'b1;
        #1;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        check_eq("rst_issue_reg1", bus.issue_reg1, 32'd0);
        check_eq("rst_issue_rob", 32'(bus.issue_rob_id), 32'd0);
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        do_reset();

        // single ready op issues the cycle after dispatch
        set_enq(5'd1, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd7);
        bus.issue_ready = 1'b1;
        do_cycle();
        idle_inputs(); bus.issue_ready = 1'b1; #1;
        check_eq("basic_valid", 32'(bus.issue_valid), 32'd1);
        check_eq("basic_reg1", bus.issue_reg1, 32'd5);
        check_eq("basic_reg2", bus.issue_reg2, 32'd7);
        check_eq("basic_op", 32'(bus.issue_op), 32'(OP_ADD));
        do_cycle();
        idle_inputs(); #1;
        check_eq("basic_count", 32'(count), 32'd0);
        do_cycle();

        // ready younger op bypasses a waiting older one; CDB wakes the older
        set_enq(5'd2, 1'b0, 5'd3, 32'd0, 1'b1, 5'd0, 32'd22);
        do_cycle();
        idle_inputs(); set_enq(5'd3, 1'b1, 5'd0, 32'd33, 1'b1, 5'd0, 32'd44);
        do_cycle();
        idle_inputs(); bus.issue_ready = 1'b1; #1;
        check_eq("bypass_rob", 32'(bus.issue_rob_id), 32'd3);
        do_cycle();
        idle_inputs(); bus.issue_ready = 1'b1; set_cdb(5'd3, 32'h1234); #1;
`ifdef ALU_RS_CDB_ISSUE_EN
        check_eq("wake_same_valid", 32'(bus.issue_valid), 32'd1);
        check_eq("wake_same_reg1", bus.issue_reg1, 32'h1234);
        check_eq("wake_same_rob", 32'(bus.issue_rob_id), 32'd2);
`else
        check_eq("wake_same_valid", 32'(bus.issue_valid), 32'd0);
`endif
        do_cycle();
        idle_inputs(); bus.issue_ready = 1'b1; #1;
`ifdef ALU_RS_CDB_ISSUE_EN
        check_eq("wake_next_valid", 32'(bus.issue_valid), 32'd0);
        check_eq("wake_next_count", 32'(count), 32'd0);
`else
        check_eq("wake_next_valid", 32'(bus.issue_valid), 32'd1);
        check_eq("wake_next_reg1", bus.issue_reg1, 32'h1234);
        check_eq("wake_next_rob", 32'(bus.issue_rob_id), 32'd2);
`endif
        do_cycle();

        // fill, then a freed slot is reusable only on the following cycle
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            set_enq(5'(8 + i), 1'b1, 5'd0, 32'(i), 1'b1, 5'd0, 32'(i + 100));
            do_cycle();
        end
        idle_inputs(); #1;
        check_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("full_count", 32'(count), 32'd4);
        set_enq(5'd12, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd2); bus.issue_ready = 1'b1; #1;
        check_eq("full_same_cycle_ready", 32'(bus.in_ready), 32'd0);
        check_eq("full_issue_rob", 32'(bus.issue_rob_id), 32'd8);
        do_cycle();
        set_enq(5'd13, 1'b1, 5'd0, 32'd3, 1'b1, 5'd0, 32'd4); bus.issue_ready = 1'b0; #1;
        check_eq("full_next_ready", 32'(bus.in_ready), 32'd1);
        check_eq("full_next_count", 32'(count), 32'd3);
        do_cycle();
        idle_inputs(); bus.issue_ready = 1'b1;
        repeat (5) do_cycle();

        // operand satisfied by the CDB during its own dispatch
        idle_inputs();
        set_enq(5'd14, 1'b1, 5'd0, 32'h55, 1'b0, 5'd9, 32'd0); set_cdb(5'd9, 32'hFFFF_0000); bus.issue_ready = 1'b1;
        do_cycle();
        idle_inputs(); bus.issue_ready = 1'b1; #1;
        check_eq("enq_wake_valid", 32'(bus.issue_valid), 32'd1);
        check_eq("enq_wake_reg2", bus.issue_reg2, 32'hFFFF_0000);
        do_cycle();

        // flush beats enqueue and issue
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            set_enq(5'(16 + i), 1'b1, 5'd0, 32'(i), 1'b1, 5'd0, 32'(i));
            do_cycle();
        end
        set_enq(5'd20, 1'b1, 5'd0, 32'd9, 1'b1, 5'd0, 32'd9); bus.issue_ready = 1'b1; flush = 1'b1; #1;
        check_eq("flush_issue_valid", 32'(bus.issue_valid), 32'd0);
        check_eq("flush_in_ready", 32'(bus.in_ready), 32'd0);
        do_cycle();
        idle_inputs(); #1;
        check_eq("flush_count", 32'(count), 32'd0);
        do_cycle();

        // age beats index: younger entry placed in a lower slot than the older one
        set_enq(5'd15, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd1);
        do_cycle();
        set_enq(5'd10, 1'b0, 5'd4, 32'd0, 1'b1, 5'd0, 32'd1);
        do_cycle();
        idle_inputs(); bus.issue_ready = 1'b1;
        do_cycle();
        idle_inputs(); set_enq(5'd11, 1'b1, 5'd0, 32'd2, 1'b0, 5'd4, 32'd0);
        do_cycle();
        idle_inputs(); set_cdb(5'd4, 32'hABCD);
        do_cycle();
        idle_inputs(); bus.issue_ready = 1'b1; #1;
        check_eq("age_first_rob", 32'(bus.issue_rob_id), 32'd10);
        check_eq("age_first_reg1", bus.issue_reg1, 32'hABCD);
        do_cycle();
        idle_inputs(); bus.issue_ready = 1'b1; #1;
        check_eq("age_second_rob", 32'(bus.issue_rob_id), 32'd11);
        check_eq("age_second_reg2", bus.issue_reg2, 32'hABCD);
        do_cycle();

        // randomized traffic with a reset in the middle
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                do_reset();
            end
            bus.in_valid    = ($urandom_range(0, 99) < 60);
            bus.in_op       = 4'($urandom_range(0, 15));
            bus.in_pc       = $urandom;
            bus.in_instr    = $urandom;
            bus.in_rob_id   = 5'($urandom_range(0, 31));
            bus.in_rdy1     = ($urandom_range(0, 1) == 1);
            bus.in_tag1     = 5'($urandom_range(0, 7));
            bus.in_val1     = $urandom;
            bus.in_rdy2     = ($urandom_range(0, 1) == 1);
            bus.in_tag2     = 5'($urandom_range(0, 7));
            bus.in_val2     = $urandom;
            bus.cdb_valid   = ($urandom_range(0, 99) < 50);
            bus.cdb_tag     = 5'($urandom_range(0, 7));
            bus.cdb_data    = $urandom;
            bus.issue_ready = ($urandom_range(0, 99) < 70);
            flush           = ($urandom_range(0, 99) < 3);
            do_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
